// File: rtl/uart_pkg.sv
// uart_pkg: shared UART timing helpers, state encodings and counter widths
// Ports: none (package)
package uart_pkg;
  localparam int BIT_CNT_W = 4;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
  function automatic int clks_per_bit(int clk_freq, int baud);
    return (clk_freq + baud / 2) / baud;
  endfunction
  function automatic int half_bit(int clk_freq, int baud);
    return clks_per_bit(clk_freq, baud) / 2;
  endfunction
  function automatic int cnt_width(int cpb);
    return cpb > 2 ? $clog2(cpb) : 1;
  endfunction
endpackage

// File: rtl/uart_rx.sv
// uart_rx: 8N1 receiver with input synchronizers, mid-bit sampling and framing check
// Ports: clk, rst (async, active-high), rxd_pin (raw serial in), sw (raw receive enable),
//        rx_data (received word), rx_valid (one-cycle strobe per valid frame)
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLK_FREQ = 100_000_000,
  parameter int BAUD     = 9_600,
  parameter int WORDSZ   = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rxd_pin,
  input  logic              sw,
  output logic [WORDSZ-1:0] rx_data,
  output logic              rx_valid
);
  localparam int CPB  = clks_per_bit(CLK_FREQ, BAUD);
  localparam int HALF = half_bit(CLK_FREQ, BAUD);
  localparam int CW   = cnt_width(CPB);
  rx_state_t            state;
  logic [1:0]           rxd_s, sw_s;
  logic [CW-1:0]        cnt;
  logic [BIT_CNT_W-1:0] bit_cnt;
  logic [WORDSZ-1:0]    shift;
  logic                 ferr;
  logic                 rxd, en, last;
  assign rxd  = rxd_s[1];
  assign en   = sw_s[1];
  assign last = cnt == CW'(CPB - 1);
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      rxd_s    <= 2'b11;
      sw_s     <= 2'b00;
      state    <= RX_IDLE;
      cnt      <= '0;
      bit_cnt  <= '0;
      shift    <= '0;
      rx_data  <= '0;
      rx_valid <= 1'b0;
      ferr     <= 1'b0;
    end else begin
      rxd_s    <= {rxd_s[0], rxd_pin};
      sw_s     <= {sw_s[0], sw};
      rx_valid <= 1'b0;
      if (!en) begin
        state <= RX_IDLE;
        cnt   <= '0;
      end else
        case (state)
          RX_IDLE: begin
            cnt <= '0;
            // a framing error leaves the line low; wait for it to return high first
            if (ferr) ferr <= !rxd;
            else if (!rxd) begin
              bit_cnt <= '0;
              state   <= RX_START;
            end
          end
          RX_START:
            if (cnt == CW'(HALF - 1)) begin
              cnt   <= '0;
              state <= rxd ? RX_IDLE : RX_DATA;
            end else cnt <= cnt + 1'b1;
          RX_DATA:
            if (last) begin
              cnt     <= '0;
              shift   <= {rxd, shift[WORDSZ-1:1]};
              bit_cnt <= bit_cnt + 1'b1;
              if (bit_cnt == BIT_CNT_W'(WORDSZ - 1)) state <= RX_STOP;
            end else cnt <= cnt + 1'b1;
          default:
            if (last) begin
              cnt   <= '0;
              state <= RX_IDLE;
              if (rxd) begin
                rx_data  <= shift;
                rx_valid <= 1'b1;
              end else ferr <= 1'b1;
            end else cnt <= cnt + 1'b1;
        endcase
    end
endmodule

// File: rtl/uart_to_reg.sv
// uart_to_reg: UART receive-to-LED register bridge with byte echo on the transmit line
// Ports: CLK, RST (async, active-high), RXD_PIN (serial in), SW_0 (receive enable),
//        TXD_PIN (serial echo out, idle high), LED (last valid received byte)
module uart_to_reg
  import uart_pkg::*;
#(
  parameter int CLK_FREQ = 100_000_000,
  parameter int BAUD     = 9_600,
  parameter int WORDSZ   = 8
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              RXD_PIN,
  input  logic              SW_0,
  output logic              TXD_PIN,
  output logic [WORDSZ-1:0] LED
);
  localparam int CPB = clks_per_bit(CLK_FREQ, BAUD);
  localparam int CW  = cnt_width(CPB);
  logic [WORDSZ-1:0]    rx_data, tx_shift;
  logic                 rx_valid, tx_last;
  tx_state_t            tx_state;
  logic [CW-1:0]        tx_cnt;
  logic [BIT_CNT_W-1:0] tx_bit;
  uart_rx #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .WORDSZ(WORDSZ)) u_rx (
    .clk     (CLK),
    .rst     (RST),
    .rxd_pin (RXD_PIN),
    .sw      (SW_0),
    .rx_data (rx_data),
    .rx_valid(rx_valid)
  );
  assign tx_last = tx_cnt == CW'(CPB - 1);
  always_ff @(posedge CLK or posedge RST)
    if (RST) LED <= '0;
    else if (rx_valid) LED <= rx_data;
  // TXD_PIN is registered, so the line trails the state by one cycle while
  // each bit still lasts exactly CPB cycles.
  always_ff @(posedge CLK or posedge RST)
    if (RST) begin
      tx_state <= TX_IDLE;
      tx_cnt   <= '0;
      tx_bit   <= '0;
      tx_shift <= '0;
      TXD_PIN  <= 1'b1;
    end else
      case (tx_state)
        TX_IDLE: begin
          TXD_PIN <= 1'b1;
          tx_cnt  <= '0;
          if (rx_valid) begin
            tx_shift <= rx_data;
            tx_state <= TX_START;
          end
        end
        TX_START: begin
          TXD_PIN <= 1'b0;
          if (tx_last) begin
            tx_cnt   <= '0;
            tx_bit   <= '0;
            tx_state <= TX_DATA;
          end else tx_cnt <= tx_cnt + 1'b1;
        end
        TX_DATA: begin
          TXD_PIN <= tx_shift[0];
          if (tx_last) begin
            tx_cnt   <= '0;
            tx_shift <= {1'b0, tx_shift[WORDSZ-1:1]};
            tx_bit   <= tx_bit + 1'b1;
            if (tx_bit == BIT_CNT_W'(WORDSZ - 1)) tx_state <= TX_STOP;
          end else tx_cnt <= tx_cnt + 1'b1;
        end
        default: begin
          TXD_PIN <= 1'b1;
          // back-to-back frames deliver the next rx_valid exactly in the final
          // stop-bit cycle, so accept it here rather than dropping the echo
          if (tx_last) begin
            tx_cnt   <= '0;
            tx_state <= rx_valid ? TX_START : TX_IDLE;
            if (rx_valid) tx_shift <= rx_data;
          end else tx_cnt <= tx_cnt + 1'b1;
        end
      endcase
endmodule

// File: tb/tb_uart_to_reg.sv
// tb_uart_to_reg: self-checking bench with an echo scoreboard for uart_to_reg
module tb_uart_to_reg;
  import uart_pkg::*;
  localparam int CLK_FREQ = 153_600;
  localparam int BAUD     = 9_600;
  localparam int CPB      = 16;
  logic       CLK = 1'b0, RST = 1'b0, RXD_PIN = 1'b1, SW_0 = 1'b0;
  logic       TXD_PIN;
  logic [7:0] LED;
  logic [7:0] echo_q[$];
  logic [7:0] led_model = 8'h00;
  int         n_chk = 0, n_fail = 0;
  always #5 CLK = ~CLK;
  uart_to_reg #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .WORDSZ(8)) dut (
    .CLK    (CLK),
    .RST    (RST),
    .RXD_PIN(RXD_PIN),
    .SW_0   (SW_0),
    .TXD_PIN(TXD_PIN),
    .LED    (LED)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic idle(input int n);
    repeat (n) @(negedge CLK);
  endtask
  task automatic send(input logic [7:0] b, input logic stop, input int rst_bit = -1);
    logic [9:0] fr;
    fr = {stop, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      @(negedge CLK);
      RXD_PIN = fr[i];
      if (i == rst_bit) begin
        repeat (CPB / 2) @(negedge CLK);
        #3 RST = 1'b1;
        #1;
        check("rst_mid_led", LED, 8'h00);
        check("rst_mid_txd", TXD_PIN, 1'b1);
        led_model = 8'h00;
        @(negedge CLK);
        RST = 1'b0;
        RXD_PIN = 1'b1;
        return;
      end
      repeat (CPB - 1) @(negedge CLK);
    end
    if (SW_0 && stop) begin
      led_model = b;
      echo_q.push_back(b);
    end
  endtask
  initial begin : echo_mon
    logic [7:0] got;
    forever begin
      @(negedge CLK);
      if (TXD_PIN === 1'b0) begin
        repeat (CPB / 2 - 1) @(negedge CLK);
        check("echo_start", TXD_PIN, 1'b0);
        for (int i = 0; i < 8; i++) begin
          repeat (CPB) @(negedge CLK);
          got[i] = TXD_PIN;
        end
        if (echo_q.size() == 0) check("echo_extra", echo_q.size(), 1);
        else check("echo_data", got, echo_q.pop_front());
        repeat (CPB) @(negedge CLK);
        check("echo_stop", TXD_PIN, 1'b1);
      end
    end
  end
  initial begin
    #1 RST = 1'b1;
    idle(3);
    check("reset_led", LED, 8'h00);
    check("reset_txd", TXD_PIN, 1'b1);
    RST = 1'b0;
    SW_0 = 1'b1;
    idle(4);
    send(8'h20, 1'b1);
    check("led_20", LED, led_model);
    for (int k = 0; k < 3; k++) begin
      send(8'h20, 1'b1);
      check("led_b2b", LED, led_model);
    end
    idle(12 * CPB);
    SW_0 = 1'b0;
    idle(4);
    send(8'hA5, 1'b1);
    check("led_sw_off", LED, led_model);
    check("txd_sw_off", TXD_PIN, 1'b1);
    idle(2 * CPB);
    SW_0 = 1'b1;
    idle(4);
    send(8'h5A, 1'b1);
    check("led_5a", LED, led_model);
    idle(12 * CPB);
    send(8'hFF, 1'b0);
    @(negedge CLK);
    RXD_PIN = 1'b1;
    idle(12 * CPB);
    check("led_ferr", LED, 8'h5A);
    send(8'h3C, 1'b1);
    check("led_3c", LED, led_model);
    idle(12 * CPB);
    @(negedge CLK);
    RXD_PIN = 1'b0;
    idle(3);
    RXD_PIN = 1'b1;
    idle(3 * CPB);
    check("glitch_led", LED, 8'h3C);
    check("glitch_state", dut.u_rx.state, RX_IDLE);
    send(8'h81, 1'b1, 5);
    idle(2 * CPB);
    check("led_after_rst", LED, 8'h00);
    send(8'h81, 1'b1);
    check("led_81", LED, led_model);
    for (int i = 0; i < 20 * CPB && echo_q.size() != 0; i++) @(negedge CLK);
    idle(2 * CPB);
    check("echo_drain", echo_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
